// File: rtl/fpu_sequencer_if.sv
// Command channel into fpu_sequencer: valid/ready handshake carrying an opcode and a load word.
// The master drives commands and the slave (the sequencer) returns ready.
interface fpu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [22:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/fpu_sequencer.sv
// Accumulator front-end for the fpu add/sub core: holds R1/R2, issues start strobes, writes results back to R1.
// Optional watchdog on the wait states is enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_sequencer #(
    parameter int TIMEOUT_CYCLES = 31
) (
    input  logic           clk,
    input  logic           reset,
    fpu_sequencer_if.slave cmd,
    output logic [22:0]    r1_out,
    output logic           res_valid,
    output logic           err,
    output logic           fpu_add,
    output logic           fpu_sub,
    output logic           fpu_reg1_s,
    output logic [6:0]     fpu_reg1_e,
    output logic [14:0]    fpu_reg1_m,
    output logic           fpu_reg2_s,
    output logic [6:0]     fpu_reg2_e,
    output logic [14:0]    fpu_reg2_m,
    input  logic           fpu_res_s,
    input  logic [6:0]     fpu_res_e,
    input  logic [14:0]    fpu_res_m,
    input  logic           fpu_idle
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [1:0] OP_LOAD_R1 = 2'b00;
    localparam logic [1:0] OP_LOAD_R2 = 2'b01;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic [22:0] r1_q, r1_d;
    logic [22:0] r2_q, r2_d;
    logic        sub_q, sub_d;
    logic        res_valid_q, res_valid_d;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;
`else
    assign err = 1'b0;
`endif

    // fpu_idle is unknown right after reset, so ready is also masked while reset is held.
    assign cmd.cmd_ready = (state_q == S_IDLE) & fpu_idle & ~reset;

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        sub_d       = sub_q;
        res_valid_d = 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    case (cmd.cmd_op)
                        OP_LOAD_R1: r1_d = cmd.cmd_data;
                        OP_LOAD_R2: r2_d = cmd.cmd_data;
                        default: begin
                            sub_d   = cmd.cmd_op[0];
                            state_d = S_ISSUE;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
`ifdef FPU_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT_BUSY: begin
                if (!fpu_idle) begin
                    state_d = S_WAIT_DONE;
`ifdef FPU_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                // The core's result is taken raw; overflow is not screened here.
                if (fpu_idle) begin
                    r1_d        = {fpu_res_s, fpu_res_e, fpu_res_m};
                    res_valid_d = 1'b1;
                    state_d     = S_IDLE;
`ifdef FPU_SEQ_TIMEOUT_EN
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            res_valid_q <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            res_valid_q <= res_valid_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Operation select is only consulted in S_ISSUE, so it needs no reset.
    always_ff @(posedge clk) begin
        sub_q <= sub_d;
    end

    assign res_valid = res_valid_q;
    assign fpu_add   = (state_q == S_ISSUE) & ~sub_q;
    assign fpu_sub   = (state_q == S_ISSUE) &  sub_q;
    assign r1_out    = r1_q;
    assign {fpu_reg1_s, fpu_reg1_e, fpu_reg1_m} = r1_q;
    assign {fpu_reg2_s, fpu_reg2_e, fpu_reg2_m} = r2_q;
endmodule
